// File: rtl/rx_deser_fifo_if.sv
// Bus bundle between the serial front end / consumer and rx_deser_fifo.
// slave = deserializer side, master = line driver and consumer side.
interface rx_deser_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic                          strt_beg;
  logic                          d;
  logic                          rx_err;
  logic [1:0]                    parity_mode;
  logic [DATA_W-1:0]             data;
  logic                          data_valid;
  logic                          data_ready;
  logic                          parity_error;
  logic                          frame_drop;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport slave (
    input  strt_beg, d, rx_err, parity_mode, data_ready,
    output data, data_valid, parity_error, frame_drop, overflow, fifo_count
  );

  modport master (
    output strt_beg, d, rx_err, parity_mode, data_ready,
    input  data, data_valid, parity_error, frame_drop, overflow, fifo_count
  );
endinterface

// File: rtl/rx_deser_fifo.sv
// Serial frame deserializer with parity/error screening feeding a FWFT FIFO.
// Optional saturating error counters are enabled with the RX_ERR_CNT_EN macro.
module rx_deser_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  rx_deser_fifo_if.slave bus
`ifdef RX_ERR_CNT_EN
  ,
  output logic [7:0] parity_err_cnt,
  output logic [7:0] overflow_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, DATA, PAR, COMMIT} state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  shreg_reg, shreg_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [1:0]         mode_reg, mode_next;
  logic               err_reg, err_next;
  logic               par_bit_reg, par_bit_next;

  logic               parity_error_reg, parity_error_next;
  logic               frame_drop_reg, frame_drop_next;
  logic               overflow_reg, overflow_next;

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg, count_next;

  logic               par_en;
  logic               par_ok;
  logic               full;
  logic               pop;
  logic               push;
  logic               valid;

  assign par_en = (mode_reg == 2'b01) || (mode_reg == 2'b10);
  assign valid  = (count_reg != '0);
  assign full   = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop    = valid && bus.data_ready;

  always_comb begin
    par_ok = 1'b1;
    case (mode_reg)
      2'b01:   par_ok = (par_bit_reg == (^shreg_reg));
      2'b10:   par_ok = (par_bit_reg == (~^shreg_reg));
      default: par_ok = 1'b1;
    endcase
  end

  // Frame assembly: bits arrive LSB first, so a right shift leaves bit 0 at the bottom.
  always_comb begin
    state_next        = state_reg;
    shreg_next        = shreg_reg;
    idx_next          = idx_reg;
    mode_next         = mode_reg;
    err_next          = err_reg;
    par_bit_next      = par_bit_reg;
    parity_error_next = 1'b0;
    frame_drop_next   = 1'b0;
    overflow_next     = 1'b0;
    push              = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.strt_beg) begin
          shreg_next = {bus.d, shreg_reg[DATA_W-1:1]};
          idx_next   = IDX_W'(1);
          mode_next  = bus.parity_mode;
          err_next   = bus.rx_err;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bus.strt_beg) begin
          shreg_next = {bus.d, shreg_reg[DATA_W-1:1]};
          err_next   = err_reg | bus.rx_err;
          idx_next   = idx_reg + IDX_W'(1);
          if (idx_reg == IDX_W'(DATA_W - 1)) begin
            state_next = par_en ? PAR : COMMIT;
          end
        end
      end
      PAR: begin
        if (bus.strt_beg) begin
          par_bit_next = bus.d;
          err_next     = err_reg | bus.rx_err;
          state_next   = COMMIT;
        end
      end
      COMMIT: begin
        state_next = IDLE;
        if (err_reg) begin
          frame_drop_next = 1'b1;
        end else if (!par_ok) begin
          parity_error_next = 1'b1;
        end else if (full && !pop) begin
          overflow_next = 1'b1;
        end else begin
          push = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      shreg_reg        <= '0;
      idx_reg          <= '0;
      mode_reg         <= '0;
      err_reg          <= 1'b0;
      par_bit_reg      <= 1'b0;
      parity_error_reg <= 1'b0;
      frame_drop_reg   <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      shreg_reg        <= shreg_next;
      idx_reg          <= idx_next;
      mode_reg         <= mode_next;
      err_reg          <= err_next;
      par_bit_reg      <= par_bit_next;
      parity_error_reg <= parity_error_next;
      frame_drop_reg   <= frame_drop_next;
      overflow_reg     <= overflow_next;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset; pointer and count reset make stale words unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= shreg_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= PTR_W'((32'(wr_ptr_reg) + 1) % FIFO_DEPTH);
      end
      if (pop) begin
        rd_ptr_reg <= PTR_W'((32'(rd_ptr_reg) + 1) % FIFO_DEPTH);
      end
      count_reg <= count_next;
    end
  end

  // First-word fall-through: head word is read asynchronously and masked while empty.
  assign bus.data         = valid ? mem[rd_ptr_reg] : '0;
  assign bus.data_valid   = valid;
  assign bus.fifo_count   = count_reg;
  assign bus.parity_error = parity_error_reg;
  assign bus.frame_drop   = frame_drop_reg;
  assign bus.overflow     = overflow_reg;

`ifdef RX_ERR_CNT_EN
  logic [7:0] parity_err_cnt_reg;
  logic [7:0] overflow_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_cnt_reg <= '0;
      overflow_cnt_reg   <= '0;
    end else begin
      if (parity_error_next && (parity_err_cnt_reg != 8'hFF)) begin
        parity_err_cnt_reg <= parity_err_cnt_reg + 8'd1;
      end
      if (overflow_next && (overflow_cnt_reg != 8'hFF)) begin
        overflow_cnt_reg <= overflow_cnt_reg + 8'd1;
      end
    end
  end

  assign parity_err_cnt = parity_err_cnt_reg;
  assign overflow_cnt   = overflow_cnt_reg;
`endif

endmodule

// File: tb/tb_rx_deser_fifo.sv
// Directed and randomized frame stimulus for rx_deser_fifo, checked against a
// frame-level queue model.
module tb_rx_deser_fifo;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rx_deser_fifo_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

`ifdef RX_ERR_CNT_EN
  logic [7:0] parity_err_cnt;
  logic [7:0] overflow_cnt;
`endif

  rx_deser_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RX_ERR_CNT_EN
    ,
    .parity_err_cnt (parity_err_cnt),
    .overflow_cnt   (overflow_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] q[$];
  int exp_perr_cnt = 0;
  int exp_ovf_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    logic [31:0] exp_data;
    exp_data = (q.size() > 0) ? 32'(q[0]) : 32'd0;
    check({tag, " fifo_count"}, 32'(bus.fifo_count), 32'(q.size()));
    check({tag, " data_valid"}, 32'(bus.data_valid), 32'(q.size() > 0));
    check({tag, " data"}, 32'(bus.data), exp_data);
  endtask

  task automatic check_pulses(input string tag, input bit e_drop, input bit e_perr, input bit e_ovf);
    check({tag, " frame_drop"}, 32'(bus.frame_drop), 32'(e_drop));
    check({tag, " parity_error"}, 32'(bus.parity_error), 32'(e_perr));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(e_ovf));
  endtask

  // Caller is always positioned 1 time unit after a rising edge.
  task automatic send_frame(input logic [15:0] w, input logic [1:0] mode, input logic pb,
                            input logic [16:0] errm, input bit pop_c, input string tag);
    int  nb;
    bit  par_en, err, parok, e_drop, e_perr, e_ovf;
    int  ones;
    par_en = (mode == 2'b01) || (mode == 2'b10);
    nb = DATA_W + (par_en ? 1 : 0);
    bus.parity_mode = mode;
    err = 1'b0;
    for (int i = 0; i < nb; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.strt_beg = 1'b0;
        bus.d        = 1'($urandom);
        bus.rx_err   = 1'($urandom);
        @(posedge clk); #1;
      end
      bus.strt_beg = 1'b1;
      bus.d        = (i < DATA_W) ? w[i] : pb;
      bus.rx_err   = errm[i];
      err = err | errm[i];
      @(posedge clk); #1;
      bus.parity_mode = 2'($urandom);
    end
    // Commit cycle: strt_beg noise must be ignored.
    bus.strt_beg   = 1'($urandom);
    bus.d          = 1'($urandom);
    bus.rx_err     = 1'($urandom);
    bus.data_ready = pop_c;

    ones = $countones(w[DATA_W-1:0]);
    if (mode == 2'b01)      parok = (pb == 1'(ones % 2));
    else if (mode == 2'b10) parok = (pb == 1'((ones + 1) % 2));
    else                    parok = 1'b1;
    if (pop_c && q.size() > 0) void'(q.pop_front());
    e_drop = err;
    e_perr = !err && !parok;
    e_ovf  = !err && parok && (q.size() == FIFO_DEPTH);
    if (!e_drop && !e_perr && !e_ovf) q.push_back(w & 16'((1 << DATA_W) - 1));
    if (e_perr && exp_perr_cnt < 255) exp_perr_cnt++;
    if (e_ovf && exp_ovf_cnt < 255) exp_ovf_cnt++;

    @(posedge clk); #1;
    bus.strt_beg   = 1'b0;
    bus.rx_err     = 1'b0;
    bus.data_ready = 1'b0;
    check_pulses(tag, e_drop, e_perr, e_ovf);
    check_fifo(tag);
    $display("frame %s: word=%0h mode=%0d pb=%0d err=%0d pop=%0d -> drop=%0d perr=%0d ovf=%0d count=%0d",
             tag, w, mode, pb, err, pop_c, e_drop, e_perr, e_ovf, q.size());
    @(posedge clk); #1;
    check_pulses({tag, " after"}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 2 * FIFO_DEPTH) begin
      bus.data_ready = 1'b1;
      check({tag, " pop valid"}, 32'(bus.data_valid), 32'd1);
      check({tag, " pop data"}, 32'(bus.data), 32'(q[0]));
      $display("pop %s: data=%0h expected=%0h", tag, bus.data, q[0]);
      @(posedge clk); #1;
      void'(q.pop_front());
      guard++;
    end
    bus.data_ready = 1'b0;
    @(posedge clk); #1;
    check_fifo({tag, " drained"});
  endtask

  function automatic logic good_par(input logic [15:0] w, input logic [1:0] mode);
    int ones;
    ones = $countones(w[DATA_W-1:0]);
    return (mode == 2'b10) ? 1'((ones + 1) % 2) : 1'(ones % 2);
  endfunction

  initial begin
    rst = 1'b1;
    bus.strt_beg = 1'b0; bus.d = 1'b0; bus.rx_err = 1'b0;
    bus.parity_mode = 2'b00; bus.data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_pulses("reset", 1'b0, 1'b0, 1'b0);
    check_fifo("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    send_frame(16'hA5, 2'b01, 1'b0, 17'h0, 1'b0, "even_a5");
    drain("even_a5");
    send_frame(16'h3C, 2'b10, 1'b0, 17'h0, 1'b0, "odd_3c_bad");
    send_frame(16'h81, 2'b00, 1'b0, 17'h8, 1'b0, "drop_81");
    send_frame(16'h7E, 2'b00, 1'b0, 17'h0, 1'b0, "clean_7e");
    send_frame(16'h5A, 2'b01, 1'b0, 17'h100, 1'b0, "drop_parbit");
    drain("clean_7e");

    for (int i = 0; i < 5; i++) begin
      send_frame(16'(8'h10 + i), 2'b00, 1'b0, 17'h0, 1'b0, $sformatf("fill%0d", i));
    end
    send_frame(16'hC3, 2'b01, good_par(16'hC3, 2'b01), 17'h0, 1'b1, "full_pop");
    drain("full_pop");

    send_frame(16'h11, 2'b00, 1'b0, 17'h0, 1'b0, "pre_rst0");
    send_frame(16'h22, 2'b00, 1'b0, 17'h0, 1'b0, "pre_rst1");
    for (int i = 0; i < 5; i++) begin
      bus.strt_beg = 1'b1; bus.d = 1'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b1; bus.strt_beg = 1'b1; bus.data_ready = 1'b1;
    q.delete();
    exp_perr_cnt = 0; exp_ovf_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_pulses($sformatf("in_rst%0d", i), 1'b0, 1'b0, 1'b0);
      check_fifo($sformatf("in_rst%0d", i));
    end
    rst = 1'b0; bus.strt_beg = 1'b0; bus.data_ready = 1'b0;
    @(posedge clk); #1;
    send_frame(16'h55, 2'b00, 1'b0, 17'h0, 1'b0, "post_rst_55");
    drain("post_rst_55");

    for (int n = 0; n < 40; n++) begin
      logic [15:0] w;
      logic [1:0]  mode;
      logic        pb;
      logic [16:0] errm;
      w    = 16'($urandom_range(0, 255));
      mode = 2'($urandom);
      pb   = good_par(w, mode);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      errm = ($urandom_range(0, 5) == 0) ? 17'(1 << $urandom_range(0, DATA_W)) : 17'h0;
      send_frame(w, mode, pb, errm, 1'($urandom), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 4) == 0) drain($sformatf("rnd%0d", n));
    end
    drain("final");

`ifdef RX_ERR_CNT_EN
    check("parity_err_cnt", 32'(parity_err_cnt), 32'(exp_perr_cnt));
    check("overflow_cnt", 32'(overflow_cnt), 32'(exp_ovf_cnt));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
